// File: rtl/mux_pkg.sv
// Shared definitions for the N-way selector family: select-width helpers
// and the output-stage state encoding.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n, input int unsigned onehot);
    return (onehot != 0) ? n : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N-way selector with binary or one-hot select and an
// error flag for invalid selects (out of range, none set, or several set).
module mux_n_sel
  import mux_pkg::*;
#(
  parameter int unsigned LENGTH = 32,
  parameter int unsigned N      = 4,
  parameter int unsigned ONEHOT = 0,
  localparam int unsigned SELW  = sel_width(N, ONEHOT)
) (
  input  logic [N*LENGTH-1:0] in_flat,
  input  logic [SELW-1:0]     sel,
  output logic [LENGTH-1:0]   data,
  output logic                err
);

  if (ONEHOT == 0) begin : g_binary
    always_comb begin
      data = '0;
      err  = 1'b1;
      for (int unsigned k = 0; k < N; k++) begin
        if (sel == SELW'(k)) begin
          data = in_flat[k*LENGTH +: LENGTH];
          err  = 1'b0;
        end
      end
    end
  end else begin : g_onehot
    always_comb begin
      int unsigned cnt;
      logic        found;
      data  = '0;
      cnt   = 0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        if (sel[k]) begin
          cnt = cnt + 1;
          if (!found) begin
            data  = in_flat[k*LENGTH +: LENGTH];
            found = 1'b1;
          end
        end
      end
      err = (cnt != 1);
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way selector behind a valid/ready output stage with a 2-entry skid
// buffer; every output, including in_ready, is driven straight from a flop.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int unsigned LENGTH = 32,
  parameter int unsigned N      = 4,
  parameter int unsigned ONEHOT = 0,
  localparam int unsigned SELW  = sel_width(N, ONEHOT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [N*LENGTH-1:0] in_flat,
  input  logic [SELW-1:0]     sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [LENGTH-1:0]   out,
  output logic                out_sel_err,
  output logic                out_valid,
  input  logic                out_ready
);

  pipe_state_t       state, state_nx;
  logic [LENGTH-1:0] sel_data, skid_data;
  logic              sel_err, skid_err;
  logic              accept, xfer;
  logic              load_main, main_from_skid, load_skid;

  mux_n_sel #(
    .LENGTH (LENGTH),
    .N      (N),
    .ONEHOT (ONEHOT)
  ) u_sel (
    .in_flat (in_flat),
    .sel     (sel),
    .data    (sel_data),
    .err     (sel_err)
  );

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY:   if (accept) state_nx = FULL;
        FULL: begin
          if (!accept && xfer)      state_nx = EMPTY;
          else if (accept && !xfer) state_nx = SKID;
        end
        SKID:    if (xfer) state_nx = FULL;
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      unique case (state)
        EMPTY: load_main = accept;
        FULL: begin
          load_main = accept & xfer;
          load_skid = accept & ~xfer;
        end
        SKID: begin
          load_main      = xfer;
          main_from_skid = xfer;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags are recomputed from the next state so they come off flops
  // rather than decoding the state register combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_valid <= (state_nx != EMPTY);
      in_ready  <= (state_nx != SKID);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out         <= '0;
      out_sel_err <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
    end else begin
      if (load_main) begin
        out         <= main_from_skid ? skid_data : sel_data;
        out_sel_err <= main_from_skid ? skid_err  : sel_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_err;
      end
    end
  end

endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-way selector with a registered, flow-controlled output. It generalises the fixed 2/3/4-input muxes to any input count, binary or one-hot select, and a defined out-of-range response, behind a valid/ready stage with a 2-entry skid buffer. It sits between pipeline stages wherever a datapath select (forwarding, writeback source, PC source) must also absorb stalls and flushes.

## Interface
- LENGTH, 32, data width per input (≥1)
- N, 4, number of inputs (≥2)
- ONEHOT, 0, 0 = binary select, 1 = one-hot select
- SELW (derived, not overridable): ONEHOT ? N : clog2(N)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  drop all buffered entries and the current input beat
- in_flat  input  N*LENGTH  inputs; input k occupies bits [k*LENGTH +: LENGTH]
- sel  input  SELW  select, sampled with the input beat
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat
- out  output  LENGTH  selected data
- out_sel_err  output  1  select was invalid for this beat
- out_valid  output  1  output beat present
- out_ready  input  1  consumer accepts the beat

## Operation
- Selection, binary mode: if sel < N, then data = input[sel] and err = 0. Otherwise data = 0 and err = 1 (only possible when N is not a power of 2).
- Selection, one-hot mode:
  - exactly one bit set: that input, err = 0
  - no bits set: data = 0, err = 1
  - more than one bit set: the lowest-index set bit wins, err = 1
- Data and err travel together through the buffer as one entry.
- Input handshake: accept when in_valid & in_ready. Output handshake: transfer when out_valid & out_ready.
- in_ready = !skid_valid. It is registered state, with no combinational path from out_ready.
- State machine:
  - EMPTY: main invalid. Accept → FULL.
  - FULL: main valid, skid empty.
    - accept and transfer → FULL (main reloaded)
    - transfer only → EMPTY
    - accept only → SKID (beat goes to skid)
  - SKID: main and skid both valid, in_ready = 0.
    - transfer → FULL (skid moves to main, skid cleared)
    - no transfer → SKID
- Ordering is strict FIFO. No beat is duplicated or lost except by flush or reset.
- Flush has priority over every handshake:
  - next state EMPTY
  - an input beat offered in the same cycle is discarded
  - out_valid drops the next cycle
  - data registers are not required to clear
- Reset: state EMPTY; out = 0, out_sel_err = 0, out_valid = 0, in_ready = 1 from the first cycle after reset. Handshakes during the reset cycle are ignored.

## Timing
- Latency is 1 cycle: a beat accepted at edge t appears on out/out_valid after edge t.
- Throughput is 1 beat/cycle with out_ready held high, and the block stays in FULL.
- out, out_sel_err and out_valid come directly from flops. in_ready also comes from a flop.
- While out_valid = 1 and out_ready = 0, out and out_sel_err are held stable.
- Reset asserted mid-transfer beats flush. No beat issues after the reset edge.

## Structure
- Shared package mux_pkg:
  - function sel_width(N, ONEHOT)
  - clog2 helper
  - state encoding localparams EMPTY/FULL/SKID
- Sub-module mux_n_sel holds the combinational selector. Parameters LENGTH, N, ONEHOT; ports in_flat, sel, data, err. It is reusable standalone as the N-way successor of the fixed muxes.
- mux_n_pipe instantiates mux_n_sel once and adds the main/skid registers and the state machine.

## Test plan
- N=4, binary, out_ready = 1; inputs 0x11/0x22/0x33/0x44, sel = 0,1,2,3 on consecutive cycles → out = 0x11,0x22,0x33,0x44 one cycle later, err = 0, in_ready stays 1.
- N=3, binary, sel = 3 → out = 0, out_sel_err = 1. N=4, one-hot: sel = 0b0110 → input1 with err = 1; sel = 0 → 0 with err = 1.
- Back-pressure: send A, B, C with out_ready = 0 → in_ready falls after B is accepted and C is held off. Raise out_ready → out delivers A, B, C in order with no gaps once draining.
- Flush in SKID with in_valid = 1 (beat D) → next cycle out_valid = 0 and in_ready = 1; D never appears on out.
- Reset asserted in FULL with out_ready = 0 → next cycle out_valid = 0, out = 0, out_sel_err = 0; a new beat afterward flows with 1-cycle latency.
- Random valid/ready over 10k beats for N=5 and ONEHOT=1 → scoreboard matches order and values, err matches the reference model.
